// File: rtl/mc_pkg.sv
// mc_pkg: state, class and datapath-select encodings shared by the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWR = 4'd5, S_RTEXE = 4'd6, S_RTWB = 4'd7, S_BEQEX = 4'd8, S_IEXE = 4'd9,
    S_IWB = 4'd10, S_JEX = 4'd11, S_ILL = 4'd12
  } state_t;
  typedef enum logic [2:0] {C_MEM, C_RT, C_BEQ, C_IMM, C_J, C_ILL} cls_t;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FN = 3'd2, ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4, ALU_OR = 3'd5, ALU_XOR = 3'd6;
  localparam logic [1:0] SRCB_B = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_BR = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0, PC_OUT = 2'd1, PC_JMP = 2'd2;
  localparam logic [5:0] OP_RT = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
endpackage

// File: rtl/mc_opclass.sv
// mc_opclass: maps the opcode to an instruction class plus immediate-op ALU controls
module mc_opclass
  import mc_pkg::*;
(
  input  logic [5:0] op,
  output cls_t       cls,
  output logic [2:0] aluop,
  output logic       hassign,
  output logic       islui
);
  logic w_imm;
  assign w_imm = op[5:3] == 3'b001;
  assign cls = (op == OP_LW || op == OP_SW) ? C_MEM :
               op == OP_RT  ? C_RT  :
               op == OP_BEQ ? C_BEQ :
               w_imm        ? C_IMM :
               op == OP_J   ? C_J   : C_ILL;
  assign aluop = !w_imm ? ALU_ADD :
                 op[2] ? (op[1:0] == 2'b00 ? ALU_AND : op[1:0] == 2'b01 ? ALU_OR :
                          op[1:0] == 2'b10 ? ALU_XOR : ALU_ADD) :
                 (op[1] ? ALU_SLT : ALU_ADD);
  // signed variants are the even opcodes ADDI and SLTI
  assign hassign = w_imm && !op[2] && !op[0];
  assign islui   = w_imm && op[2:0] == 3'b111;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore multicycle CPU controller with memory-ready handshakes
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       hassign,
  output logic       islui,
  output logic       illegal,
  output logic [3:0] state
);
  state_t     r_state, w_next;
  cls_t       w_cls;
  logic [2:0] w_aluop;
  logic       w_hassign, w_islui;
  mc_opclass u_opclass (.op(op), .cls(w_cls), .aluop(w_aluop), .hassign(w_hassign), .islui(w_islui));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_cls == C_MEM ? S_MEMADR : w_cls == C_RT ? S_RTEXE :
                         w_cls == C_BEQ ? S_BEQEX : w_cls == C_IMM ? S_IEXE :
                         w_cls == C_J ? S_JEX : S_ILL;
      S_MEMADR: w_next = op == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_rdy ? S_FETCH : S_MEMWR;
      S_RTEXE:  w_next = S_RTWB;
      S_IEXE:   w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end
  always_comb begin
    {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca} = '0;
    {hassign, islui, illegal} = '0;
    alusrcb = SRCB_B;
    pcsrc   = PC_ALU;
    aluop   = ALU_ADD;
    case (r_state)
      S_FETCH:  begin memread = 1'b1; alusrcb = SRCB_4; irwrite = mem_rdy; pcen = mem_rdy; end
      S_DECODE: alusrcb = SRCB_BR;
      S_MEMADR: begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
      S_MEMRD:  begin memread = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; end
      S_MEMWR:  begin memwrite = 1'b1; iord = 1'b1; end
      S_RTEXE:  begin alusrca = 1'b1; aluop = ALU_FN; end
      S_RTWB:   begin regwrite = 1'b1; regdst = 1'b1; end
      S_BEQEX:  begin alusrca = 1'b1; aluop = ALU_SUB; pcsrc = PC_OUT; pcen = zero; end
      S_IEXE:   begin alusrca = 1'b1; alusrcb = SRCB_IMM; aluop = w_aluop; hassign = w_hassign; islui = w_islui; end
      S_IWB:    begin regwrite = 1'b1; aluop = w_aluop; hassign = w_hassign; islui = w_islui; end
      S_JEX:    begin pcsrc = PC_JMP; pcen = 1'b1; end
      S_ILL:    illegal = 1'b1;
      default:  ;
    endcase
    // reset must suppress strobes even though FETCH mirrors mem_rdy
    if (rst) {pcen, irwrite, regwrite, memwrite, illegal} = '0;
  end
  assign state = r_state;
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
No parameters.
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port `op`, input, 6 bits: opcode field of the instruction register, stable from DECODE until return to FETCH.
REQ-004 The block SHALL have the port `zero`, input, 1 bit: ALU zero flag.
REQ-005 The block SHALL have the port `mem_rdy`, input, 1 bit: memory access completes this cycle.
REQ-006 The block SHALL have the outputs `pcen`, `iord`, `memread`, `memwrite`, `irwrite`, `regdst`, `memtoreg`, `regwrite` and `alusrca`, each 1 bit: datapath strobes and selects.
REQ-007 The block SHALL have the output `alusrcb`, 2 bits: 00 = regB, 01 = constant 4, 10 = extended immediate, 11 = sign-extended immediate<<2.
REQ-008 The block SHALL have the output `pcsrc`, 2 bits: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-009 The block SHALL have the output `aluop`, 3 bits: 000 = add, 001 = sub, 010 = funct field, 011 = slt, 100 = and, 101 = or, 110 = xor.
REQ-010 The block SHALL have the outputs `hassign`, `islui` and `illegal`, each 1 bit.
REQ-011 The block SHALL have the output `state`, 4 bits: current state, for debug.

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BEQEX=8, IEXE=9, IWB=10, JEX=11, ILL=12; codes 13-15 SHALL go to FETCH.
REQ-013 FETCH SHALL drive memread=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00; irwrite and pcen SHALL equal mem_rdy; the FSM SHALL hold in FETCH while mem_rdy=0 and go to DECODE when mem_rdy=1.
REQ-014 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=000 and branch on op: 100011/101011 to MEMADR; 000000 to RTEXE; 000100 to BEQEX; 001000-001111 to IEXE; 000010 to JEX; any other value to ILL.
REQ-015 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=000, then go to MEMRD for LW or to MEMWR for SW.
REQ-016 MEMRD SHALL drive memread=1, iord=1, hold while mem_rdy=0, and go to MEMWB when mem_rdy=1.
REQ-017 MEMWB SHALL drive regwrite=1, memtoreg=1, regdst=0, then go to FETCH.
REQ-018 MEMWR SHALL drive memwrite=1, iord=1; memwrite SHALL stay high while holding for mem_rdy, then the FSM SHALL go to FETCH.
REQ-019 RTEXE SHALL drive alusrca=1, alusrcb=00, aluop=010, then go to RTWB; RTWB SHALL drive regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
REQ-020 BEQEX SHALL drive alusrca=1, alusrcb=00, aluop=001, pcsrc=01, pcen=zero, then go to FETCH.
REQ-021 IEXE SHALL drive alusrca=1, alusrcb=10 and the per-opcode `aluop`/`hassign`/`islui` values below, then go to IWB; IWB SHALL drive regwrite=1, regdst=0, memtoreg=0 and keep the IEXE `aluop`/`hassign`/`islui` values, then go to FETCH.
- 001000 ADDI: aluop 000, hassign 1, islui 0.
- 001001 ADDIU: aluop 000, hassign 0, islui 0.
- 001010 SLTI: aluop 011, hassign 1, islui 0.
- 001011 SLTIU: aluop 011, hassign 0, islui 0.
- 001100 ANDI: aluop 100, hassign 0, islui 0.
- 001101 ORI: aluop 101, hassign 0, islui 0.
- 001110 XORI: aluop 110, hassign 0, islui 0.
- 001111 LUI: aluop 000, hassign 0, islui 1.
REQ-022 JEX SHALL drive pcsrc=10, pcen=1, then go to FETCH.
REQ-023 ILL SHALL drive illegal=1 for exactly one cycle, write no state, then go to FETCH; the PC is already incremented.
REQ-024 In every state, any output not listed for that state SHALL be 0.
REQ-025 Cycle counts from FETCH entry to the next FETCH entry with mem_rdy=1 throughout SHALL be: LW 5, SW 4, R-type 4, I-type 4, BEQ 3, J 3, illegal 3; each memory wait cycle SHALL add exactly 1.

Reset
REQ-026 While rst=1, the state SHALL be FETCH asynchronously and pcen, irwrite, regwrite, memwrite and illegal SHALL be forced to 0 regardless of mem_rdy.
REQ-027 Assertion of rst in any state, including mid-wait in MEMWR, SHALL abort the instruction with no further strobes.
REQ-028 After rst deasserts, the FSM SHALL begin a fetch at the next rising edge.

Structure
REQ-029 Package mc_pkg SHALL hold the state encodings, the aluop codes, the alusrcb/pcsrc codes and the opcode constants.
REQ-030 The combinational sub-module mc_opclass SHALL map op to an instruction class (MEM, RT, BEQ, IMM, J, ILL) plus aluop/hassign/islui; the FSM SHALL use its outputs in DECODE/IEXE/IWB.
REQ-031 Next-state logic and output logic SHALL be separate combinational blocks; only the state register SHALL be clocked.

Verification
REQ-032 Reset, then mem_rdy=1 and op=000000 -> state sequence 0,1,6,7,0; regwrite=1 with regdst=1 only in cycle 4.
REQ-033 op=100011 with mem_rdy low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; memtoreg=1 and regwrite=1 in state 4.
REQ-034 op=000100 with zero=1, then zero=0 -> pcen=1 in BEQEX on the first pass, pcen=0 on the second.
REQ-035 op=001010 -> aluop=011 and hassign=1 in IEXE and IWB; op=001111 -> islui=1 and aluop=000.
REQ-036 op=111111 -> sequence 0,1,12,0; illegal pulses exactly 1 cycle; regwrite, memwrite and pcen all 0 in state 12.
REQ-037 rst asserted mid-MEMWR while mem_rdy=0 -> state=0 immediately; memwrite=0 in the same cycle; a normal fetch follows rst release.
